// File: rtl/register_file_32x32.sv
// -----------------------------------------------------------------------------
// register_file_32x32
//
// Purpose:
//   General-purpose register file for the datapath. One write port (driven by
//   the WB stage) and two independent combinational read ports (serving the ID
//   stage). The write index is demuxed into a one-hot set of per-register
//   write enables, so exactly one register updates on a write.
//   With ZERO_REG != 0, register 0 ignores writes and always reads as zero.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - when defined, a write in flight is forwarded to any
//                       read port addressing the same register in the same
//                       cycle (WB->ID forwarding). When undefined, reads see
//                       stored contents only.
//
// Parameters:
//   DATA_WIDTH  register / data width
//   ADDR_WIDTH  index width, depth = 2**ADDR_WIDTH
//   ZERO_REG    1: register 0 hardwired to zero, 0: ordinary storage
//
// Ports:
//   Clk            in   system clock, rising-edge active
//   Reset          in   asynchronous active-high reset, clears every register
//   RegWrite       in   write enable for this cycle
//   WriteRegister  in   destination index
//   WriteData      in   data to store
//   ReadRegister1  in   read port 1 index
//   ReadRegister2  in   read port 2 index
//   ReadData1      out  read port 1 data (combinational)
//   ReadData2      out  read port 2 data (combinational)
// -----------------------------------------------------------------------------
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // One-hot write enables; at most one bit is set in any cycle.
    logic [DEPTH-1:0]      w_write_sel;
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // -------------------------------------------------------------------------
    // Write index decode. Register 0 never gets an enable when it is hardwired,
    // so a suppressed write cannot reach storage or the bypass path.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign w_write_sel[gi] = 1'b0;
            end else begin : g_sel
                assign w_write_sel[gi] = RegWrite &&
                                         (WriteRegister == ADDR_WIDTH'(gi));
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Storage. Asynchronous reset clears everything immediately and wins over
    // a write on a coinciding edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_write_sel[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports. Index 0 is forced to zero when hardwired, independent of
    // whatever the storage cell holds.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rd1 = r_regs[ReadRegister1];
        w_rd2 = r_regs[ReadRegister2];
        if ((ZERO_REG != 0) && (ReadRegister1 == '0)) begin
            w_rd1 = '0;
        end
        if ((ZERO_REG != 0) && (ReadRegister2 == '0)) begin
            w_rd2 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        // w_write_sel already folds in RegWrite, the index match and the
        // register-0 suppression, so indexing it by the read index tells us
        // whether this port's register is being written right now.
        if (!Reset && w_write_sel[ReadRegister1]) begin
            w_rd1 = WriteData;
        end
        if (!Reset && w_write_sel[ReadRegister2]) begin
            w_rd2 = WriteData;
        end
`endif
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;

endmodule

// File: tb/tb_register_file_32x32.sv
// -----------------------------------------------------------------------------
// tb_register_file_32x32
//
// Purpose:
//   Self-checking bench for register_file_32x32 (default parameters, register 0
//   hardwired). Directed scenarios followed by randomized traffic, all checked
//   against an array-based reference model. Follows REGFILE_BYPASS_EN the same
//   way the design does, so it works with the macro defined or not.
// -----------------------------------------------------------------------------
module tb_register_file_32x32;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: plain array of architectural register values.
    logic [31:0] model_mem [32];

    always #5 Clk = ~Clk;

    register_file_32x32 #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .ZERO_REG   (1)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected read value from the architectural rules.
    function automatic logic [31:0] model_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && !Reset && (WriteRegister == ra)) return WriteData;
`endif
        return model_mem[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    endtask

    // One clock transaction: drive at negedge, check reads before the edge,
    // update the model at the rising edge.
    task automatic xact(input string tag, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra1,
                        input logic [4:0] ra2);
        @(negedge Clk);
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = ra1;
        ReadRegister2 = ra2;
        #1;
        check({tag, ".rd1"}, ReadData1, model_read(ra1));
        check({tag, ".rd2"}, ReadData2, model_read(ra2));
        $display("%s we=%0b wa=%0d wd=%08h ra1=%0d rd1=%08h ra2=%0d rd2=%08h",
                 tag, we, wa, wd, ra1, ReadData1, ra2, ReadData2);
        @(posedge Clk);
        if (we && wa != 5'd0) model_mem[wa] = wd;
    endtask

    // Read every register through both ports (port 2 walks the other way).
    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            xact(tag, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end
    endtask

    initial begin
        Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        model_clear();

        // Reset state.
        @(negedge Clk);
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd31;
        #1;
        check("reset.r5", ReadData1, 32'h0);
        check("reset.r31", ReadData2, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // 1. Mid-sim asynchronous reset clears r5 immediately.
        xact("t1.wr", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        xact("t1.rd", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        model_clear();
        check("t1.rst_hi", ReadData1, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        read_all("t1.all");

        // 2. Write r31, read on both ports next cycle.
        xact("t2.wr", 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31);
        xact("t2.rd", 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        check("t2.r31", ReadData1, 32'h12345678);

        // 3. Write to r0 is ignored; the others are untouched.
        xact("t3.wr", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        read_all("t3.all");

        // 4. RegWrite low: r7 keeps its value.
        xact("t4.nowr", 1'b0, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        xact("t4.rd", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        check("t4.r7", ReadData1, 32'h0);

        // 5. Same-cycle write/read of r9 (bypass-dependent), then visible after.
        xact("t5.wr", 1'b1, 5'd9, 32'h00000042, 5'd9, 5'd1);
        xact("t5.rd", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        check("t5.r9", ReadData2, 32'h00000042);

        // 6. Reset on the same edge as a write: reset wins.
        xact("t6.pre", 1'b1, 5'd3, 32'h11, 5'd3, 5'd3);
        @(negedge Clk);
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h77;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
        #4 Reset = 1'b1;
        @(posedge Clk);
        #1;
        model_clear();
        check("t6.rst_edge", ReadData1, 32'h0);
        @(negedge Clk);
        Reset = 1'b0; RegWrite = 1'b0;
        #1;
        check("t6.after", ReadData2, 32'h0);

        // 6b. Distinct value per index, then read back.
        for (int i = 0; i < 32; i++) begin
            xact("t6.fill", 1'b1, 5'(i), 32'hC0DE0000 + 32'(i * 7919), 5'd0, 5'd0);
        end
        read_all("t6.all");

        // Randomized traffic, with frequent read/write index collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            logic [4:0] ra1;
            logic [4:0] ra2;
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            xact("rand", 1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
